// File: rtl/memif_if.sv
// memif_if: bundle of the serdes and dual-port memory signals seen by the memif bridge.
//   dataReady        serdes has a complete inPacket (rising edge = transfer)
//   inPacket         received packet from the serdes
//   outPacket        packet the serdes shifts out on the next transfer
//   rd_addr/rd_data  memory read port (rd_data arrives one cycle after rd_addr)
//   wr_addr/wr_data  memory write port, qualified by the one-cycle wr_enable strobe
//   inPacketIsValid  combinational framing check of inPacket
// The slave modport is the bridge's view; the master modport is the serdes/memory side.
interface memif_if #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
);
    localparam int unsigned PACKET_WIDTH = WORD_WIDTH + 4;

    logic                    dataReady;
    logic [PACKET_WIDTH-1:0] inPacket;
    logic [PACKET_WIDTH-1:0] outPacket;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [WORD_WIDTH-1:0]   rd_data;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [WORD_WIDTH-1:0]   wr_data;
    logic                    wr_enable;
    logic                    inPacketIsValid;

    modport master (
        output dataReady, inPacket, rd_data,
        input  outPacket, rd_addr, wr_addr, wr_data, wr_enable, inPacketIsValid
    );

    modport slave (
        input  dataReady, inPacket, rd_data,
        output outPacket, rd_addr, wr_addr, wr_data, wr_enable, inPacketIsValid
    );
endinterface

// File: rtl/memif.sv
// memif: packet-to-memory bridge between an SPI serdes and a dual-port memory.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    memif_if.slave (serdes packet handshake plus memory read/write ports)
// After reset or resync the first valid packet sets the read pointer, the second sets
// the write pointer, and every following packet is written to memory. Each cycle the
// memory word at the read pointer is framed into outPacket for the next transfer.
module memif #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input logic   clk,
    input logic   reset,
    memif_if.slave bus
);
    localparam int unsigned PW = WORD_WIDTH + 4;
    localparam int unsigned NW = WORD_WIDTH / 2;
    localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;

    typedef enum logic [1:0] {StRdAddr, StWrAddr, StData} state_t;

    state_t                state_q;
    logic                  ready_prev_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [WORD_WIDTH-1:0] wr_data_q;
    logic                  wr_enable_q;
    logic [PW-1:0]         out_packet_q;

    logic [WORD_WIDTH-1:0] word;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  packet_valid;
    logic                  transfer;

    function automatic logic [PW-1:0] pack(input logic [WORD_WIDTH-1:0] w);
        return {2'b01, w[WORD_WIDTH-1:NW], 2'b10, w[NW-1:0]};
    endfunction

    assign word         = {bus.inPacket[PW-3:NW+2], bus.inPacket[NW-1:0]};
    assign packet_valid = (bus.inPacket[PW-1:PW-2] == 2'b01) &&
                          (bus.inPacket[NW+1:NW] == 2'b10);
    // Only the rising edge of dataReady counts, so a held level is a single transfer.
    assign transfer     = bus.dataReady && !ready_prev_q;

    generate
        if (ADDR_WIDTH <= WORD_WIDTH) begin : g_addr_trunc
            assign word_addr = word[ADDR_WIDTH-1:0];
        end else begin : g_addr_zext
            assign word_addr = {{(ADDR_WIDTH - WORD_WIDTH){1'b0}}, word};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StRdAddr;
            ready_prev_q <= 1'b0;
            rd_addr_q    <= '0;
            wr_ptr_q     <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_enable_q  <= 1'b0;
            out_packet_q <= pack('0);
        end else begin
            ready_prev_q <= bus.dataReady;
            wr_enable_q  <= 1'b0;
            out_packet_q <= pack(bus.rd_data);
            if (transfer) begin
                if (!packet_valid) begin
                    // Bad framing is the host's resync request: restart at the read address.
                    state_q <= StRdAddr;
                end else begin
                    unique case (state_q)
                        StRdAddr: begin
                            rd_addr_q <= word_addr;
                            state_q   <= StWrAddr;
                        end
                        StWrAddr: begin
                            wr_ptr_q <= word_addr;
                            state_q  <= StData;
                        end
                        StData: begin
                            wr_addr_q   <= wr_ptr_q;
                            wr_data_q   <= word;
                            wr_enable_q <= 1'b1;
                            wr_ptr_q    <= wr_ptr_q + AddrOne;
                            rd_addr_q   <= rd_addr_q + AddrOne;
                        end
                        default: state_q <= StRdAddr;
                    endcase
                end
            end
        end
    end

    assign bus.rd_addr         = rd_addr_q;
    assign bus.wr_addr         = wr_addr_q;
    assign bus.wr_data         = wr_data_q;
    assign bus.wr_enable       = wr_enable_q;
    assign bus.outPacket       = out_packet_q;
    assign bus.inPacketIsValid = packet_valid;
endmodule

// File: tb/tb_memif.sv
// tb_memif: directed and randomized transfers against memif with a fake memory
// (rd_data <= rd_addr), checked against a transfer-level model of the protocol.
module tb_memif;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    // Model: count of valid packets since resync, plus the two base addresses.
    int         phase;
    logic [7:0] rd_base;
    logic [7:0] wr_base;
    logic [7:0] exp_rd;

    always #5 clk = ~clk;

    memif_if #(.WORD_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    memif #(.WORD_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Fake memory: each location holds its own address.
    always_ff @(posedge clk) bus.rd_data <= bus.rd_addr;

    function automatic logic [11:0] pack(input logic [7:0] w);
        return {2'b01, w[7:4], 2'b10, w[3:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reset with a valid packet pending on dataReady, which must be ignored.
    task automatic do_reset(input int cycles, input string tag);
        @(negedge clk);
        reset = 1'b1;
        bus.dataReady = 1'b1;
        bus.inPacket = pack(8'h77);
        repeat (cycles) @(negedge clk);
        bus.dataReady = 1'b0;
        reset = 1'b0;
        phase = 0;
        exp_rd = 8'h00;
        repeat (3) @(negedge clk);
        check({tag, ":outPacket"}, bus.outPacket, 12'h420);
        check({tag, ":wr_enable"}, bus.wr_enable, 1'b0);
        check({tag, ":rd_addr"}, bus.rd_addr, 8'h00);
        check({tag, ":wr_addr"}, bus.wr_addr, 8'h00);
    endtask

    task automatic send(input logic [11:0] pkt, input int hold, input string tag);
        logic       exp_valid;
        logic [7:0] word;
        logic       exp_we;
        logic [7:0] exp_wa;
        int         we_cnt;
        logic [7:0] wa;
        logic [7:0] wd;
        exp_valid = (pkt[11:10] == 2'b01) && (pkt[5:4] == 2'b10);
        word = {pkt[9:6], pkt[3:0]};
        @(negedge clk);
        bus.inPacket = pkt;
        bus.dataReady = 1'b1;
        #1;
        check({tag, ":valid"}, bus.inPacketIsValid, exp_valid);
        we_cnt = 0;
        wa = 8'h00;
        wd = 8'h00;
        for (int i = 0; i < hold + 5; i++) begin
            @(negedge clk);
            if (bus.wr_enable !== 1'b0) begin
                we_cnt++;
                wa = bus.wr_addr;
                wd = bus.wr_data;
            end
            if (i == hold - 1) bus.dataReady = 1'b0;
        end
        exp_we = 1'b0;
        exp_wa = 8'h00;
        if (!exp_valid) begin
            phase = 0;
        end else if (phase == 0) begin
            rd_base = word;
            exp_rd = word;
            phase = 1;
        end else if (phase == 1) begin
            wr_base = word;
            phase = 2;
        end else begin
            exp_we = 1'b1;
            exp_wa = wr_base + 8'(phase - 2);
            exp_rd = rd_base + 8'(phase - 1);
            phase++;
        end
        check({tag, ":writes"}, we_cnt, exp_we ? 1 : 0);
        if (exp_we) begin
            check({tag, ":wr_addr"}, wa, exp_wa);
            check({tag, ":wr_data"}, wd, word);
        end
        check({tag, ":rd_addr"}, bus.rd_addr, exp_rd);
        check({tag, ":outPacket"}, bus.outPacket, pack(exp_rd));
    endtask

    initial begin
        logic [11:0] pkt;
        int          r;
        reset = 1'b1;
        bus.dataReady = 1'b0;
        bus.inPacket = '0;
        phase = 0;
        rd_base = 8'h00;
        wr_base = 8'h00;
        exp_rd = 8'h00;

        do_reset(3, "reset");

        send(pack(8'h05), 1, "rd_addr");
        send(pack(8'h0d), 1, "wr_addr");
        send(pack(8'h5f), 1, "data0");
        send(pack(8'h11), 1, "data1");
        send(pack(8'h22), 5, "held");
        send(12'h000, 1, "invalid");
        send(pack(8'h03), 1, "resync_rd");

        send(pack(8'h10), 1, "wrap_wp_badpos");
        send(pack(8'hFE), 2, "wrap_rd");
        send(12'h000, 3, "wrap_sync");
        send(pack(8'hFE), 1, "wrap_rd2");
        send(pack(8'hFF), 1, "wrap_wr");
        send(pack(8'hA1), 1, "wrap_d0");
        send(pack(8'hA2), 1, "wrap_d1");
        send(pack(8'hA3), 1, "wrap_d2");

        do_reset(2, "midreset");
        send(pack(8'h40), 1, "post_rst_rd");
        send(pack(8'h41), 1, "post_rst_wr");
        send(pack(8'h99), 2, "post_rst_d0");

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) pkt = 12'h000;
            else if (r == 1) pkt = 12'($urandom);
            else pkt = pack(8'($urandom));
            send(pkt, $urandom_range(1, 4), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
